// File: rtl/bist_session_scheduler_pkg.sv
// Shared constants for the BIST session scheduler: default widths, test indices, FSM encoding.
package bist_session_scheduler_pkg;

    localparam int unsigned DEF_ADDR_W    = 8;
    localparam int unsigned DEF_NUM_TESTS = 4;
    localparam int unsigned DEF_TMO_W     = 12;
    localparam int unsigned DEF_FCNT_W    = 8;
    localparam int unsigned DEF_SEL_W     = 2;

    localparam logic [DEF_SEL_W-1:0] TEST_BL = 2'd0;
    localparam logic [DEF_SEL_W-1:0] TEST_CH = 2'd1;
    localparam logic [DEF_SEL_W-1:0] TEST_MC = 2'd2;
    localparam logic [DEF_SEL_W-1:0] TEST_MA = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PICK   = 3'd1,
        ST_BRST   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/bist_session_scheduler_if.sv
// Link between the session scheduler (master) and the SRAM BIST engine (slave).
interface bist_session_scheduler_if
    import bist_session_scheduler_pkg::*;
#(
    parameter int unsigned AW = DEF_ADDR_W,
    parameter int unsigned SW = DEF_SEL_W
) ();

    logic          bist_rst;
    logic          bist_start;
    logic [SW-1:0] bist_test_sel;
    logic          bist_fail;
    logic          bist_test_done;
    logic [AW-1:0] bist_fail_addr;

    modport master (
        output bist_rst, bist_start, bist_test_sel,
        input  bist_fail, bist_test_done, bist_fail_addr
    );

    modport slave (
        input  bist_rst, bist_start, bist_test_sel,
        output bist_fail, bist_test_done, bist_fail_addr
    );

endinterface

// File: rtl/bist_result_log.sv
// Per-session result log: pass/fail vectors, first failing address per test, fail count, timeout.
module bist_result_log
    import bist_session_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_TESTS = DEF_NUM_TESTS,
    parameter int unsigned FCNT_W    = DEF_FCNT_W,
    parameter int unsigned SEL_W     = DEF_SEL_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic                          valid_i,
    input  logic [SEL_W-1:0]              cur_i,
    input  logic                          fail_i,
    input  logic [ADDR_W-1:0]             fail_addr_i,
    input  logic                          done_i,
    input  logic                          expire_i,
    output logic [NUM_TESTS-1:0]          pass_vec,
    output logic [NUM_TESTS-1:0]          fail_vec,
    output logic [NUM_TESTS*ADDR_W-1:0]   first_fail_addr,
    output logic [FCNT_W-1:0]             fail_count,
    output logic                          timeout
);

    logic [NUM_TESTS-1:0]        pass_q, pass_d;
    logic [NUM_TESTS-1:0]        fail_q, fail_d;
    logic [NUM_TESTS*ADDR_W-1:0] ffa_q, ffa_d;
    logic [FCNT_W-1:0]           cnt_q, cnt_d;
    logic                        tmo_q, tmo_d;

    // Same-cycle fail is folded in before the pass verdict; test_done beats watchdog expiry.
    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        ffa_d  = ffa_q;
        cnt_d  = cnt_q;
        tmo_d  = tmo_q;
        if (clear_i) begin
            pass_d = '0;
            fail_d = '0;
            ffa_d  = '0;
            cnt_d  = '0;
            tmo_d  = 1'b0;
        end else if (valid_i) begin
            if (fail_i) begin
                if (cnt_q != '1) cnt_d = cnt_q + FCNT_W'(1);
                if (!fail_q[cur_i]) begin
                    fail_d[cur_i]                    = 1'b1;
                    ffa_d[cur_i*ADDR_W +: ADDR_W]    = fail_addr_i;
                end
            end
            if (done_i) begin
                pass_d[cur_i] = ~fail_d[cur_i];
            end else if (expire_i) begin
                fail_d[cur_i] = 1'b1;
                tmo_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass_q <= '0;
            fail_q <= '0;
            ffa_q  <= '0;
            cnt_q  <= '0;
            tmo_q  <= 1'b0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            ffa_q  <= ffa_d;
            cnt_q  <= cnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign pass_vec        = pass_q;
    assign fail_vec        = fail_q;
    assign first_fail_addr = ffa_q;
    assign fail_count      = cnt_q;
    assign timeout         = tmo_q;

endmodule

// File: rtl/bist_session_scheduler.sv
// Runs every enabled BIST algorithm in turn for one session request, with a per-test watchdog.
module bist_session_scheduler
    import bist_session_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned NUM_TESTS = DEF_NUM_TESTS,
    parameter int unsigned TMO_W     = DEF_TMO_W,
    parameter int unsigned FCNT_W    = DEF_FCNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        go,
    input  logic                        abort,
    input  logic [NUM_TESTS-1:0]        test_mask,
    output logic                        busy,
    output logic                        done,
    bist_session_scheduler_if.master    bist,
    output logic [NUM_TESTS-1:0]        pass_vec,
    output logic [NUM_TESTS-1:0]        fail_vec,
    output logic [NUM_TESTS*ADDR_W-1:0] first_fail_addr,
    output logic [FCNT_W-1:0]           fail_count,
    output logic                        timeout
);

    localparam int unsigned      SEL_W     = $clog2(NUM_TESTS);
    localparam logic [TMO_W-1:0] WDOG_LAST = ~TMO_W'(1);

    state_e               state_q, state_d;
    logic [NUM_TESTS-1:0] pending_q, pending_d;
    logic [SEL_W-1:0]     cur_q, cur_d;
    logic [TMO_W-1:0]     wdog_q, wdog_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 brst_q, brst_d;
    logic                 start_q, start_d;
    logic [SEL_W-1:0]     sel_q, sel_d;

    logic                 go_ok_c;
    logic                 in_busy_c;
    logic                 log_valid_c;
    logic                 expire_c;
    logic [SEL_W-1:0]     low_c;

    assign go_ok_c     = (state_q == ST_IDLE) && go && !abort;
    assign in_busy_c   = state_q inside {ST_PICK, ST_BRST, ST_SETTLE, ST_RUN};
    assign log_valid_c = (state_q == ST_RUN) && !abort;
    assign expire_c    = (wdog_q == WDOG_LAST);

    // Lowest pending test index.
    always_comb begin
        low_c = '0;
        for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
            if (pending_q[i]) low_c = SEL_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            wdog_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            brst_q    <= 1'b1;
            start_q   <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            wdog_q    <= wdog_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            brst_q    <= brst_d;
            start_q   <= start_d;
            sel_q     <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort && in_busy_c) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   if (go_ok_c) state_d = ST_PICK;
                ST_PICK:   state_d = (pending_q == '0) ? ST_DONE : ST_BRST;
                ST_BRST:   state_d = ST_SETTLE;
                ST_SETTLE: state_d = ST_RUN;
                ST_RUN:    if (bist.bist_test_done || expire_c) state_d = ST_PICK;
                ST_DONE:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Pending mask, current test and watchdog.
    always_comb begin
        pending_d = pending_q;
        cur_d     = cur_q;
        wdog_d    = wdog_q;
        if (go_ok_c) pending_d = test_mask;
        if (state_q == ST_PICK && pending_q != '0) begin
            cur_d     = low_c;
            pending_d = pending_q & ~(NUM_TESTS'(1) << low_c);
        end
        if (state_q == ST_SETTLE)   wdog_d = '0;
        else if (state_q == ST_RUN) wdog_d = wdog_q + TMO_W'(1);
    end

    // Outputs are decoded from the next state so the registered copies track state_q.
    always_comb begin
        busy_d  = state_d inside {ST_PICK, ST_BRST, ST_SETTLE, ST_RUN};
        done_d  = (state_d == ST_DONE);
        brst_d  = state_d inside {ST_IDLE, ST_PICK, ST_BRST, ST_DONE};
        start_d = (state_d == ST_RUN);
        sel_d   = sel_q;
        if (state_d == ST_BRST)      sel_d = cur_d;
        else if (state_d == ST_IDLE) sel_d = '0;
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign bist.bist_rst      = brst_q;
    assign bist.bist_start    = start_q;
    assign bist.bist_test_sel = sel_q;

    bist_result_log #(
        .ADDR_W    (ADDR_W),
        .NUM_TESTS (NUM_TESTS),
        .FCNT_W    (FCNT_W),
        .SEL_W     (SEL_W)
    ) u_log (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear_i         (go_ok_c),
        .valid_i         (log_valid_c),
        .cur_i           (cur_q),
        .fail_i          (bist.bist_fail),
        .fail_addr_i     (bist.bist_fail_addr),
        .done_i          (bist.bist_test_done),
        .expire_i        (expire_c),
        .pass_vec        (pass_vec),
        .fail_vec        (fail_vec),
        .first_fail_addr (first_fail_addr),
        .fail_count      (fail_count),
        .timeout         (timeout)
    );

endmodule

// File: tb/tb_bist_session_scheduler.sv
// Directed bench for bist_session_scheduler with a cycle-level BIST engine stub.
module tb_bist_session_scheduler;
    import bist_session_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        abort;
    logic [3:0]  test_mask;
    logic        busy;
    logic        done;
    logic [3:0]  pass_vec;
    logic [3:0]  fail_vec;
    logic [31:0] first_fail_addr;
    logic [7:0]  fail_count;
    logic        timeout;

    bist_session_scheduler_if #(.AW(8), .SW(2)) bist_if ();

    bist_session_scheduler dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .go              (go),
        .abort           (abort),
        .test_mask       (test_mask),
        .busy            (busy),
        .done            (done),
        .bist            (bist_if),
        .pass_vec        (pass_vec),
        .fail_vec        (fail_vec),
        .first_fail_addr (first_fail_addr),
        .fail_count      (fail_count),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         s_lat;
    int         s_starts;
    int         s_max_run;
    int         s_done_cnt;
    logic [7:0] s_seq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Launch a session and play the BIST engine: test_done after len RUN cycles (0 = never),
    // fail strobes at RUN cycles fa/fb (or every cycle when fall), optional abort/reset.
    task automatic run_session(input logic [3:0] mask, input int len,
                               input int fa, input logic [7:0] aa,
                               input int fb, input logic [7:0] ab,
                               input bit fall, input int abort_at, input int rst_at);
        int run;
        bit prev;
        run = 0; prev = 1'b0;
        s_lat = 0; s_starts = 0; s_max_run = 0; s_done_cnt = 0; s_seq = '0;
        go = 1'b1; test_mask = mask;
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clk);
            go = 1'b0; abort = 1'b0;
            bist_if.bist_fail = 1'b0; bist_if.bist_test_done = 1'b0; bist_if.bist_fail_addr = '0;
            if (done) begin
                s_done_cnt++;
                s_lat = c;
                break;
            end
            if (bist_if.bist_start) begin
                if (!prev) begin
                    s_starts++;
                    s_seq = {s_seq[5:0], bist_if.bist_test_sel};
                end
                prev = 1'b1;
                run++;
                if (run > s_max_run) s_max_run = run;
                if (fall || run == fa) begin
                    bist_if.bist_fail = 1'b1; bist_if.bist_fail_addr = aa;
                end else if (run == fb) begin
                    bist_if.bist_fail = 1'b1; bist_if.bist_fail_addr = ab;
                end
                if (len != 0 && run == len) bist_if.bist_test_done = 1'b1;
                if (abort_at != 0 && bist_if.bist_test_sel == 2'd1 && run == abort_at) begin
                    abort = 1'b1;
                    break;
                end
                if (rst_at != 0 && run == rst_at) begin
                    rst_n = 1'b0;
                    break;
                end
            end else begin
                run = 0;
                prev = 1'b0;
            end
        end
    endtask

    // One cycle after the done pulse: back in IDLE.
    task automatic chk_tail(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_brst"}, bist_if.bist_rst, 1'b1);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; go = 1'b0; abort = 1'b0; test_mask = '0;
        bist_if.bist_fail = 1'b0; bist_if.bist_test_done = 1'b0; bist_if.bist_fail_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_brst", bist_if.bist_rst, 1'b1);
        chk("rst_start", bist_if.bist_start, 1'b0);
        chk("rst_sel", bist_if.bist_test_sel, 2'd0);
        chk("rst_logs", {pass_vec, fail_vec, first_fail_addr, fail_count, timeout}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fault-free, all four tests.
        run_session(4'b1111, 5, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0);
        chk("t1_lat", s_lat, 34);
        chk("t1_seq", s_seq, 8'h1B);
        chk("t1_pass", pass_vec, 4'hF);
        chk("t1_fail", fail_vec, 4'h0);
        chk("t1_cnt", fail_count, 8'd0);
        chk("t1_tmo", timeout, 1'b0);
        chk_tail("t1");

        // Stuck-at fault in BL: first address kept, later fail only counted.
        run_session(4'b0001, 10, 3, 8'h5A, 6, 8'h77, 1'b0, 0, 0);
        chk("t2_lat", s_lat, 15);
        chk("t2_fail", fail_vec, 4'b0001);
        chk("t2_pass", pass_vec, 4'b0000);
        chk("t2_ffa", first_fail_addr, 32'h0000_005A);
        chk("t2_cnt", fail_count, 8'd2);
        chk_tail("t2");

        // Fail on the test_done cycle itself.
        run_session(4'b0010, 4, 4, 8'h3C, 0, 8'h00, 1'b0, 0, 0);
        chk("t2b_seq", s_seq, 8'h01);
        chk("t2b_fail", fail_vec, 4'b0010);
        chk("t2b_pass", pass_vec, 4'b0000);
        chk("t2b_ffa", first_fail_addr, 32'h0000_3C00);
        chk("t2b_cnt", fail_count, 8'd1);
        chk_tail("t2b");

        // Fail every cycle for 300 cycles: counter saturates.
        run_session(4'b1000, 300, 0, 8'hA5, 0, 8'h00, 1'b1, 0, 0);
        chk("t2c_cnt_sat", fail_count, 8'hFF);
        chk("t2c_fail", fail_vec, 4'b1000);
        chk("t2c_ffa", first_fail_addr, 32'hA500_0000);
        chk_tail("t2c");

        // Empty mask: done two cycles after go, engine never started, logs cleared.
        run_session(4'b0000, 5, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0);
        chk("t3_lat", s_lat, 2);
        chk("t3_starts", s_starts, 0);
        chk("t3_logs", {pass_vec, fail_vec, first_fail_addr, fail_count, timeout}, '0);
        chk_tail("t3");

        // Stuck engine: watchdog expires after 4095 RUN cycles.
        run_session(4'b0100, 0, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0);
        chk("t4_run_len", s_max_run, 4095);
        chk("t4_lat", s_lat, 4100);
        chk("t4_tmo", timeout, 1'b1);
        chk("t4_fail", fail_vec, 4'b0100);
        chk("t4_pass", pass_vec, 4'b0000);
        chk_tail("t4");

        // Sparse mask; timeout from the previous session must be cleared.
        run_session(4'b0101, 3, 0, 8'h00, 0, 8'h00, 1'b0, 0, 0);
        chk("t4b_seq", s_seq, 8'h02);
        chk("t4b_starts", s_starts, 2);
        chk("t4b_pass", pass_vec, 4'b0101);
        chk("t4b_tmo", timeout, 1'b0);
        chk_tail("t4b");

        // Abort 20 cycles into test 1.
        run_session(4'b0011, 100, 0, 8'h00, 0, 8'h00, 1'b0, 20, 0);
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_brst", bist_if.bist_rst, 1'b1);
        chk("t5_start", bist_if.bist_start, 1'b0);
        chk("t5_sel", bist_if.bist_test_sel, 2'd0);
        chk("t5_pass", pass_vec, 4'b0001);
        chk("t5_fail", fail_vec, 4'b0000);
        dcnt = s_done_cnt;
        repeat (10) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("t5_no_done", dcnt, 0);

        // Reset mid-RUN after a logged fail.
        run_session(4'b0001, 0, 2, 8'h11, 0, 8'h00, 1'b0, 0, 10);
        chk("t6_pre_fail", fail_vec, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_busy", busy, 1'b0);
        chk("t6_brst", bist_if.bist_rst, 1'b1);
        chk("t6_start", bist_if.bist_start, 1'b0);
        chk("t6_logs", {done, bist_if.bist_test_sel, pass_vec, fail_vec,
                        first_fail_addr, fail_count, timeout}, '0);

        // go together with abort in IDLE is ignored.
        go = 1'b1; abort = 1'b1; test_mask = 4'hF;
        @(negedge clk);
        go = 1'b0; abort = 1'b0;
        chk("t6_goab_busy", busy, 1'b0);
        @(negedge clk);
        chk("t6_goab_busy2", busy, 1'b0);
        chk("t6_goab_start", bist_if.bist_start, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
